instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 imem_data  input  16  instruction word from instruction memory; sampled only when accepted.
REQ-004 imem_valid  input  1  imem_data valid this cycle.
REQ-005 stall  input  1  holds fetch acceptance off while high.
REQ-006 exec_done  input  1  downstream finished the current instruction.
REQ-007 flush  input  1  abandon current instruction, restart fetch.
REQ-008 fetch_req  output  1  high in FETCH state.
REQ-009 dec_valid  output  1  decoded fields valid, high in EXEC state.
REQ-010 DA, AA, BA  output  3 each  destination, A-source and B-source register addresses.
REQ-011 IM  output  6  immediate/offset field for the constant unit.
REQ-012 CS  output  1  constant sign-extend select: 0 = zero-fill, 1 = sign-extend.
REQ-013 MB, MD, RW, MW, PL, JB, BC  output  1 each  B-mux select, data-mux select, reg write, mem write, PC load, jump/branch, branch condition.
REQ-014 FS  output  4  function select to the ALU/shifter.
REQ-015 illegal  output  1  current instruction has an unassigned opcode.

Function
REQ-016 Instruction format: op = [15:12], DR = [11:9], SA = [8:6], SB = [5:3], imm6 = [5:0]; DA = DR, AA = SA, BA = SB, IM = imm6.
REQ-017 FSM states FETCH, DECODE, EXEC; FETCH is the only state entered from reset.
REQ-018 FETCH: fetch_req = 1; when imem_valid = 1 and stall = 0, latch imem_data into the instruction register and go to DECODE; otherwise stay in FETCH.
REQ-019 DECODE: exactly one cycle; register all decoded outputs from the instruction register; go to EXEC.
REQ-020 EXEC: dec_valid = 1 and decoded outputs held constant; when exec_done = 1, go to FETCH and clear RW, MW, PL, MD, MB, JB, BC, CS, illegal and FS to 0 on the same edge.
REQ-021 Latency: imem_valid accepted at edge k -> DECODE in cycle k+1 -> EXEC with dec_valid = 1 from cycle k+2; minimum issue interval 3 cycles.
REQ-022 Decode table (others 0): 0 NOP; 1 ADD RW, FS=0010; 2 SUB RW, FS=0101; 3 AND RW, FS=1000; 4 OR RW, FS=1001; 5 ADI RW, MB, CS=0, FS=0010; 6 LDI RW, MB, CS=0, FS=1100; 7 LD RW, MD; 8 ST MW; 9 BRZ PL, MB, CS=1, BC=0; A BRN PL, MB, CS=1, BC=1; B JMP PL, JB.
REQ-023 Opcodes C-F decode as NOP with illegal = 1 for the full EXEC period.
REQ-024 Priority: rst > flush > exec_done/imem_valid.
REQ-025 flush in any state: next state FETCH; all control outputs cleared; any imem_data presented that cycle is not latched.
REQ-026 exec_done outside EXEC and imem_valid outside FETCH are ignored.
REQ-027 stall has no effect in DECODE or EXEC.

Reset
REQ-028 On rst = 1 at a clock edge: state FETCH, instruction register 0x0000, all outputs 0 except fetch_req = 1 in the following cycle.
REQ-029 Reset mid-operation (DECODE or EXEC) aborts the instruction with no further RW/MW/PL assertion.

Verification
REQ-030 After reset, imem_data = 0x5AFF, imem_valid = 1 -> two cycles later dec_valid = 1, DA = 5, AA = 3, IM = 0x3F, CS = 0, MB = 1, RW = 1, FS = 0010.
REQ-031 imem_data = 0x90B0 (BRZ) -> EXEC shows PL = 1, JB = 0, BC = 0, MB = 1, CS = 1, IM = 0x30 (downstream constant 0xF0).
REQ-032 Hold exec_done = 0 for 5 EXEC cycles -> outputs stable, fetch_req = 0; exec_done = 1 -> next cycle FETCH, RW = MW = PL = 0.
REQ-033 stall = 1 with imem_valid = 1 for 3 cycles -> remains in FETCH, no latch; stall drops -> instruction accepted on that edge.
REQ-034 imem_data = 0xD123 -> EXEC with illegal = 1, RW = MW = PL = 0.
REQ-035 flush = 1 and exec_done = 1 in the same EXEC cycle -> FETCH next cycle, controls cleared; rst during EXEC of ST (0x8000) -> MW = 0 next cycle.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Purpose: three-state fetch/decode/exec controller that turns 16-bit instruction words into datapath control fields.
// Latency: a word accepted at edge k is decoded during cycle k+1, and dec_valid rises from cycle k+2 (issue interval of 3 or more cycles).
// Backpressure: fetch acceptance is held off by stall or by a missing imem_valid; EXEC holds until exec_done; flush restarts fetch from any state.
module instr_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        exec_done,
  input  logic        flush,
  output logic        fetch_req,
  output logic        dec_valid,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic [5:0]  IM,
  output logic        CS,
  output logic        MB,
  output logic        MD,
  output logic        RW,
  output logic        MW,
  output logic        PL,
  output logic        JB,
  output logic        BC,
  output logic [3:0]  FS,
  output logic        illegal
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       pl;
    logic       md;
    logic       mb;
    logic       jb;
    logic       bc;
    logic       cs;
    logic       illegal;
    logic [3:0] fs;
  } ctrl_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  ctrl_t       ctrl, dec;
  logic [2:0]  da_q, aa_q, ba_q;
  logic [5:0]  im_q;
  logic        accept;

  // Fetch acceptance: only in FETCH, with valid data, not stalled and not being flushed.
  assign accept = (state == FETCH) && imem_valid && !stall && !flush;

  // Opcode decode table from the instruction register; unlisted controls stay 0.
  always_comb begin
    dec = '0;
    case (ir[15:12])
      4'h0: ;                                                        // NOP
      4'h1: begin dec.rw = 1'b1; dec.fs = 4'b0010; end               // ADD
      4'h2: begin dec.rw = 1'b1; dec.fs = 4'b0101; end               // SUB
      4'h3: begin dec.rw = 1'b1; dec.fs = 4'b1000; end               // AND
      4'h4: begin dec.rw = 1'b1; dec.fs = 4'b1001; end               // OR
      4'h5: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 4'b0010; end // ADI
      4'h6: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 4'b1100; end // LDI
      4'h7: begin dec.rw = 1'b1; dec.md = 1'b1; end                  // LD
      4'h8: dec.mw = 1'b1;                                           // ST
      4'h9: begin dec.pl = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; end   // BRZ
      4'hA: begin dec.pl = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; dec.bc = 1'b1; end // BRN
      4'hB: begin dec.pl = 1'b1; dec.jb = 1'b1; end                  // JMP
      default: dec.illegal = 1'b1;                                   // C-F unassigned
    endcase
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem_valid && !stall) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    if (flush) state_nxt = FETCH;
  end

  // State, instruction register and registered decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 16'h0000;
      ctrl  <= '0;
      da_q  <= '0;
      aa_q  <= '0;
      ba_q  <= '0;
      im_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ir <= imem_data;
      if (flush) begin
        ctrl <= '0;
      end else if (state == DECODE) begin
        ctrl <= dec;
        da_q <= ir[11:9];
        aa_q <= ir[8:6];
        ba_q <= ir[5:3];
        im_q <= ir[5:0];
      end else if (state == EXEC && exec_done) begin
        ctrl <= '0;
      end
    end
  end

  assign fetch_req = (state == FETCH);
  assign dec_valid = (state == EXEC);
  assign DA        = da_q;
  assign AA        = aa_q;
  assign BA        = ba_q;
  assign IM        = im_q;
  assign RW        = ctrl.rw;
  assign MW        = ctrl.mw;
  assign PL        = ctrl.pl;
  assign MD        = ctrl.md;
  assign MB        = ctrl.mb;
  assign JB        = ctrl.jb;
  assign BC        = ctrl.bc;
  assign CS        = ctrl.cs;
  assign illegal   = ctrl.illegal;
  assign FS        = ctrl.fs;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Purpose: directed self-checking bench for instr_decode_stage.
// Latency: samples outputs 1 ns after each rising edge.
// Backpressure: drives stall, exec_done and flush explicitly from the stimulus sequence.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, imem_valid, stall, exec_done, flush;
  logic [15:0] imem_data;
  logic        fetch_req, dec_valid, CS, MB, MD, RW, MW, PL, JB, BC, illegal;
  logic [2:0]  DA, AA, BA;
  logic [5:0]  IM;
  logic [3:0]  FS;

  int pass_cnt = 0;
  int total    = 0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .imem_data(imem_data), .imem_valid(imem_valid),
    .stall(stall), .exec_done(exec_done), .flush(flush),
    .fetch_req(fetch_req), .dec_valid(dec_valid),
    .DA(DA), .AA(AA), .BA(BA), .IM(IM), .CS(CS), .MB(MB), .MD(MD),
    .RW(RW), .MW(MW), .PL(PL), .JB(JB), .BC(BC), .FS(FS), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present one instruction for a single accepting edge, then step into EXEC.
  task automatic issue(input logic [15:0] word);
    imem_data  = word;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("in_decode_fetch_req", {15'd0, fetch_req}, 16'd0);
    chk("in_decode_dec_valid", {15'd0, dec_valid}, 16'd0);
    step();
  endtask

  task automatic retire();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; stall = 1'b0; exec_done = 1'b0; flush = 1'b0;
    imem_data = 16'h0000;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_fetch_req", {15'd0, fetch_req}, 16'd1);
    chk("rst_dec_valid", {15'd0, dec_valid}, 16'd0);
    chk("rst_ctrl", {5'd0, RW, MW, PL, MD, MB, JB, BC, CS, illegal, 2'd0}, 16'd0);
    chk("rst_fields", {1'b0, DA, AA, BA, IM}, 16'd0);
    chk("rst_fs", {12'd0, FS}, 16'd0);

    // ADI 0x5AFF: DA=5 AA=3 BA=7 IM=3F, RW MB, FS=0010
    issue(16'h5AFF);
    chk("adi_dec_valid", {15'd0, dec_valid}, 16'd1);
    chk("adi_fields", {1'b0, DA, AA, BA, IM}, {1'b0, 3'd5, 3'd3, 3'd7, 6'h3F});
    chk("adi_ctrl", {7'd0, RW, MW, PL, MD, MB, JB, BC, CS}, 16'b1000_1000);
    chk("adi_fs", {12'd0, FS}, 16'b0010);
    // Hold in EXEC for 5 cycles total
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_dec_valid", {15'd0, dec_valid}, 16'd1);
      chk("hold_fetch_req", {15'd0, fetch_req}, 16'd0);
      chk("hold_rw_da", {12'd0, RW, DA}, {12'd0, 1'b1, 3'd5});
    end
    retire();
    chk("retire_fetch_req", {15'd0, fetch_req}, 16'd1);
    chk("retire_dec_valid", {15'd0, dec_valid}, 16'd0);
    chk("retire_ctrl", {7'd0, RW, MW, PL, MB, CS, illegal, FS[1:0]}, 16'd0);

    // BRZ 0x90B0: AA=2 BA=6 IM=30, PL MB CS, BC=0 JB=0
    issue(16'h90B0);
    chk("brz_ctrl", {7'd0, RW, MW, PL, MD, MB, JB, BC, CS}, 16'b0010_1001);
    chk("brz_fields", {1'b0, DA, AA, BA, IM}, {1'b0, 3'd0, 3'd2, 3'd6, 6'h30});
    retire();

    // Stall holds acceptance for 3 cycles
    imem_data = 16'h2E00; imem_valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_fetch_req", {15'd0, fetch_req}, 16'd1);
      chk("stall_dec_valid", {15'd0, dec_valid}, 16'd0);
    end
    stall = 1'b0; imem_data = 16'h1234;
    step();
    imem_valid = 1'b0; imem_data = 16'h0000;
    chk("unstall_fetch_req", {15'd0, fetch_req}, 16'd0);
    step();
    chk("add_dec_valid", {15'd0, dec_valid}, 16'd1);
    chk("add_ctrl", {7'd0, RW, MW, PL, MD, MB, JB, BC, CS}, 16'b1000_0000);
    chk("add_fs", {12'd0, FS}, 16'b0010);
    chk("add_fields", {1'b0, DA, AA, BA, IM}, {1'b0, 3'd1, 3'd0, 3'd6, 6'h34});
    retire();

    // LDI 0x6000: RW MB, FS=1100
    issue(16'h6000);
    chk("ldi_ctrl", {7'd0, RW, MW, PL, MD, MB, JB, BC, CS}, 16'b1000_1000);
    chk("ldi_fs", {12'd0, FS}, 16'b1100);
    retire();

    // Illegal opcode 0xD123, then flush together with exec_done
    issue(16'hD123);
    chk("ill_flag", {15'd0, illegal}, 16'd1);
    chk("ill_ctrl", {13'd0, RW, MW, PL}, 16'd0);
    step();
    chk("ill_hold", {14'd0, illegal, dec_valid}, 16'b11);
    flush = 1'b1; exec_done = 1'b1;
    step();
    flush = 1'b0; exec_done = 1'b0;
    chk("flush_state", {14'd0, fetch_req, dec_valid}, 16'b10);
    chk("flush_ill", {15'd0, illegal}, 16'd0);

    // Flush in FETCH blocks the latch
    imem_data = 16'h1000; imem_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; imem_valid = 1'b0;
    chk("flush_fetch_nolatch", {15'd0, fetch_req}, 16'd1);

    // JMP 0xB000: PL JB
    issue(16'hB000);
    chk("jmp_ctrl", {7'd0, RW, MW, PL, MD, MB, JB, BC, CS}, 16'b0010_0100);
    retire();

    // ST 0x8000 then reset in EXEC
    issue(16'h8000);
    chk("st_mw", {13'd0, RW, MW, PL}, 16'b010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_rst_mw", {15'd0, MW}, 16'd0);
    chk("st_rst_state", {14'd0, fetch_req, dec_valid}, 16'b10);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
